seq_alu: RTL and testbench

- Parametrised, registered successor to the combinational datapath ALU.
- Keeps the single-cycle ops (add, sub, and, or, slt) and adds iterative unsigned multiply and divide, producing a high word: product high half, or remainder.
- Sits in the execute stage of the multi-cycle CPU and talks to the control FSM through a start/ready/valid handshake.
- Every op has a defined result; there are no X outputs.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/seq_alu_if.sv | 26 ++
 rtl/muldiv_iter.sv | 73 +++++++
 rtl/seq_alu.sv | 115 +++++++++++
 tb/tb_seq_alu.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, state and result constants for the sequential ALU.
// Imported by the top module and the iteration datapath.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_MULU = 3'b101;
  localparam logic [2:0] OP_DIVU = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Quotient returned for a zero divisor is every bit set; replicate to width.
  localparam logic DIV_ZERO_Q = 1'b1;

endpackage

// File: rtl/seq_alu_if.sv
// Start/ready/valid request and result bundle between the control FSM
// (master) and the sequential ALU (slave).
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [2:0]       ALUControl;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output start, srcA, srcB, ALUControl,
    input  ready, valid, result, result_hi, zero, div_by_zero
  );

  modport slave (
    input  start, srcA, srcB, ALUControl,
    output ready, valid, result, result_hi, zero, div_by_zero
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath.
// hi_o/lo_o present the register values after the current step completes.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] acc_q, lo_q, opnd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_q;

  logic [WIDTH-1:0] acc_d, lo_d;
  logic [WIDTH:0]   sum, shifted, diff;

  always_comb begin
    acc_d   = acc_q;
    lo_d    = lo_q;
    sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {acc_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_q};
    if (div_q) begin
      // Remainder stays below the divisor, so bit WIDTH of diff is a clean borrow.
      if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shifted[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = sum[WIDTH:1];
      lo_d  = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else if (load_i) begin
      acc_q  <= '0;
      lo_q   <= a_i;
      opnd_q <= b_i;
      cnt_q  <= CNT_W'(WIDTH);
      div_q  <= div_i;
    end else if (step_i) begin
      acc_q  <= acc_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));
  assign hi_o   = acc_d;
  assign lo_o   = lo_d;

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU: single-cycle logic/arith ops plus iterative
// unsigned mulu/divu, behind a start/ready/valid handshake.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  seq_alu_if.slave    cpu_io
);

  state_e           state_q;
  logic             ready_q, valid_q, zero_q, dbz_q;
  logic [WIDTH-1:0] result_q, result_hi_q;

  logic             div_zero, iter_op, capture;
  logic             slt_bit;
  logic [WIDTH-1:0] sc_lo, sc_hi, it_hi, it_lo;
  logic [WIDTH-1:0] result_d, result_hi_d;
  logic             dbz_d;
  logic             it_last;

  always_comb begin
    div_zero = (cpu_io.ALUControl == OP_DIVU) && (cpu_io.srcB == '0);
    iter_op  = (cpu_io.ALUControl == OP_MULU) ||
               ((cpu_io.ALUControl == OP_DIVU) && !div_zero);
    slt_bit  = $signed(cpu_io.srcA) < $signed(cpu_io.srcB);
    sc_lo    = '0;
    sc_hi    = '0;
    case (cpu_io.ALUControl)
      OP_ADD:  sc_lo = cpu_io.srcA + cpu_io.srcB;
      OP_SUB:  sc_lo = cpu_io.srcA - cpu_io.srcB;
      OP_AND:  sc_lo = cpu_io.srcA & cpu_io.srcB;
      OP_OR:   sc_lo = cpu_io.srcA | cpu_io.srcB;
      OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_DIVU: begin
        // Only reached here with a zero divisor; nonzero divisors iterate.
        sc_lo = {WIDTH{DIV_ZERO_Q}};
        sc_hi = cpu_io.srcA;
      end
      default: begin
        sc_lo = '0;
        sc_hi = '0;
      end
    endcase

    capture     = ((state_q == ST_IDLE) && cpu_io.start && !iter_op) ||
                  ((state_q == ST_CALC) && it_last);
    result_d    = (state_q == ST_CALC) ? it_lo : sc_lo;
    result_hi_d = (state_q == ST_CALC) ? it_hi : sc_hi;
    dbz_d       = (state_q == ST_IDLE) && div_zero;
  end

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .load_i ((state_q == ST_IDLE) && cpu_io.start && iter_op),
    .step_i (state_q == ST_CALC),
    .div_i  (cpu_io.ALUControl == OP_DIVU),
    .a_i    (cpu_io.srcA),
    .b_i    (cpu_io.srcB),
    .last_o (it_last),
    .hi_o   (it_hi),
    .lo_o   (it_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
      dbz_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (capture) begin
        valid_q     <= 1'b1;
        result_q    <= result_d;
        result_hi_q <= result_hi_d;
        zero_q      <= (result_d == '0);
        dbz_q       <= dbz_d;
      end
      case (state_q)
        ST_IDLE: if (cpu_io.start) begin
          ready_q <= 1'b0;
          state_q <= iter_op ? ST_CALC : ST_DONE;
        end
        ST_CALC: if (it_last) state_q <= ST_DONE;
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_io.ready       = ready_q;
  assign cpu_io.valid       = valid_q;
  assign cpu_io.result      = result_q;
  assign cpu_io.result_hi   = result_hi_q;
  assign cpu_io.zero        = zero_q;
  assign cpu_io.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=32 and WIDTH=8: drivers push expected
// results from an arithmetic reference model, monitors pop them on valid.
module tb_seq_alu;

  localparam int W  = 32;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W))  bus ();
  seq_alu_if #(.WIDTH(W8)) bus8 ();

  seq_alu #(.WIDTH(W))  dut  (.clk(clk), .reset(reset), .cpu_io(bus.slave));
  seq_alu #(.WIDTH(W8)) dut8 (.clk(clk), .reset(reset), .cpu_io(bus8.slave));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        dbz;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  exp_t q8[$];
  exp_t e_m, e_m8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_off = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, expv);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values, masked to width.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int width);
    exp_t r;
    longint unsigned mask, ua, ub, p;
    longint sa, sb;
    mask = (64'd1 << width) - 1;
    ua = a & mask;
    ub = b & mask;
    sa = (ua >= (64'd1 << (width - 1))) ? longint'(ua) - longint'(64'd1 << width) : longint'(ua);
    sb = (ub >= (64'd1 << (width - 1))) ? longint'(ub) - longint'(64'd1 << width) : longint'(ub);
    r.op = op; r.hi = '0; r.dbz = 1'b0; r.lat = 1; r.res = '0; r.acc_cyc = 0;
    case (op)
      3'd0: r.res = 32'((ua + ub) & mask);
      3'd1: r.res = 32'((ua - ub) & mask);
      3'd2: r.res = 32'(ua & ub);
      3'd3: r.res = 32'(ua | ub);
      3'd4: r.res = (sa < sb) ? 32'd1 : 32'd0;
      3'd5: begin
        p = ua * ub;
        r.res = 32'(p & mask);
        r.hi  = 32'((p >> width) & mask);
        r.lat = width + 1;
      end
      3'd6: begin
        if (ub == 0) begin
          r.res = 32'(mask); r.hi = 32'(ua); r.dbz = 1'b1;
        end else begin
          r.res = 32'(ua / ub); r.hi = 32'(ua % ub); r.lat = width + 1;
        end
      end
      default: r.res = '0;
    endcase
    r.z = (r.res == 0);
    return r;
  endfunction

  // Called at negedge+1; returns at negedge+1 after the request is accepted.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit junk);
    exp_t e;
    int n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin @(negedge clk); #1; n++; end
    if (bus.ready !== 1'b1) begin chk("ready_timeout", 64'(bus.ready), 64'd1); return; end
    bus.start = 1'b1; bus.ALUControl = op; bus.srcA = a; bus.srcB = b;
    e = model(op, a, b, W);
    e.acc_cyc = cyc + 1;
    q.push_back(e);
    @(negedge clk); #1;
    if (junk) begin
      n = 0;
      while (bus.ready !== 1'b1 && n < 200) begin
        bus.start = 1'b1; bus.ALUControl = 3'($urandom);
        bus.srcA = $urandom; bus.srcB = $urandom;
        @(negedge clk); #1; n++;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int n = 0;
    while (bus8.ready !== 1'b1 && n < 200) begin @(negedge clk); #1; n++; end
    if (bus8.ready !== 1'b1) begin chk("ready8_timeout", 64'(bus8.ready), 64'd1); return; end
    bus8.start = 1'b1; bus8.ALUControl = op; bus8.srcA = a; bus8.srcB = b;
    e = model(op, {24'd0, a}, {24'd0, b}, W8);
    e.acc_cyc = cyc + 1;
    q8.push_back(e);
    @(negedge clk); #1;
    bus8.start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!mon_off) begin
      if (bus.valid) begin
        if (q.size() == 0) chk("unexpected_valid", 64'(bus.valid), 64'd0);
        else begin
          e_m = q.pop_front();
          $display("txn w32 op=%0d res=%h hi=%h z=%0b dbz=%0b lat=%0d", e_m.op,
                   bus.result, bus.result_hi, bus.zero, bus.div_by_zero, cyc - e_m.acc_cyc + 1);
          chk($sformatf("op%0d_result", e_m.op), 64'(bus.result), 64'(e_m.res));
          chk($sformatf("op%0d_result_hi", e_m.op), 64'(bus.result_hi), 64'(e_m.hi));
          chk($sformatf("op%0d_zero", e_m.op), 64'(bus.zero), 64'(e_m.z));
          chk($sformatf("op%0d_div_by_zero", e_m.op), 64'(bus.div_by_zero), 64'(e_m.dbz));
          chk($sformatf("op%0d_latency", e_m.op), 64'(cyc - e_m.acc_cyc + 1), 64'(e_m.lat));
          chk("ready_at_valid", 64'(bus.ready), 64'd0);
        end
      end else chk("ready_w32", 64'(bus.ready), 64'(q.size() == 0));
      if (bus8.valid) begin
        if (q8.size() == 0) chk("unexpected_valid8", 64'(bus8.valid), 64'd0);
        else begin
          e_m8 = q8.pop_front();
          $display("txn w8 op=%0d res=%h hi=%h z=%0b dbz=%0b lat=%0d", e_m8.op,
                   bus8.result, bus8.result_hi, bus8.zero, bus8.div_by_zero, cyc - e_m8.acc_cyc + 1);
          chk($sformatf("w8_op%0d_result", e_m8.op), 64'(bus8.result), 64'(e_m8.res));
          chk($sformatf("w8_op%0d_result_hi", e_m8.op), 64'(bus8.result_hi), 64'(e_m8.hi));
          chk($sformatf("w8_op%0d_zero", e_m8.op), 64'(bus8.zero), 64'(e_m8.z));
          chk($sformatf("w8_op%0d_div_by_zero", e_m8.op), 64'(bus8.div_by_zero), 64'(e_m8.dbz));
          chk($sformatf("w8_op%0d_latency", e_m8.op), 64'(cyc - e_m8.acc_cyc + 1), 64'(e_m8.lat));
        end
      end else chk("ready_w8", 64'(bus8.ready), 64'(q8.size() == 0));
    end
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int n;
    reset = 1'b1;
    bus.start = 1'b0;  bus.srcA = '0;  bus.srcB = '0;  bus.ALUControl = '0;
    bus8.start = 1'b0; bus8.srcA = '0; bus8.srcB = '0; bus8.ALUControl = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_valid", 64'(bus.valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_result_hi", 64'(bus.result_hi), 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd1);
    chk("rst_div_by_zero", 64'(bus.div_by_zero), 64'd0);
    chk("rst_ready8", 64'(bus8.ready), 64'd1);
    #1 reset = 1'b0;
    mon_off = 1'b0;
    @(negedge clk); #1;

    issue(3'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    issue(3'd1, 32'd5, 32'd7, 1'b0);
    issue(3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0);
    issue(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    issue(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(3'd6, 32'd100, 32'd7, 1'b0);
    issue(3'd6, 32'd1234, 32'd0, 1'b0);
    issue(3'd5, 32'h0001_0003, 32'h0002_0005, 1'b1);
    issue(3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
    issue(3'd3, 32'hF0F0_0000, 32'h0000_000F, 1'b0);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 300));
      issue(op, a, b, ($urandom_range(0, 5) == 0));
    end

    n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    #1;

    // Reset in the middle of a multiply: the request must vanish silently.
    mon_off = 1'b1;
    bus.start = 1'b1; bus.ALUControl = 3'd5; bus.srcA = 32'hDEAD_BEEF; bus.srcB = 32'h1234_5678;
    @(negedge clk); #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(bus.ready), 64'd1);
    chk("midrst_valid", 64'(bus.valid), 64'd0);
    #1 reset = 1'b0;
    mon_off = 1'b0;
    repeat (40) @(negedge clk);
    #1;

    issue8(3'd5, 8'hFF, 8'hFF);
    issue8(3'd6, 8'd200, 8'd9);
    issue8(3'd6, 8'd77, 8'd0);
    issue8(3'd4, 8'h80, 8'h7F);
    for (int i = 0; i < 12; i++) issue8(3'($urandom), 8'($urandom), 8'($urandom_range(0, 255)));

    n = 0;
    while ((q.size() != 0 || q8.size() != 0) && n < 500) begin @(negedge clk); n++; end
    chk("drain", 64'(q.size() + q8.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
